// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point arithmetic unit: opcodes and controller states.
package fxp_pkg;

    typedef enum logic [1:0] {
        FXP_ADD  = 2'b00,
        FXP_SUB  = 2'b01,
        FXP_MUL  = 2'b10,
        FXP_SQRT = 2'b11
    } fxp_op_e;

    typedef enum logic [2:0] {
        IDLE,
        ADDSUB,
        MUL_ACC,
        MUL_FIN,
        SQRT_IT,
        DONE
    } fxp_state_e;

endpackage

// File: rtl/fxp_arith_unit_if.sv
// Start/busy/done request bundle between the execute stage and the fixed-point unit.
interface fxp_arith_unit_if
    import fxp_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    fxp_op_e          operation;
    logic [WIDTH-1:0] operand_1;
    logic [WIDTH-1:0] operand_2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             invalid;

    modport master (
        output start, operation, operand_1, operand_2,
        input  busy, done, result, overflow, invalid
    );

    modport slave (
        input  start, operation, operand_1, operand_2,
        output busy, done, result, overflow, invalid
    );
endinterface

// File: rtl/fxp_chunk_multiplier.sv
// Combinational unsigned chunk multiplier, time-shared across the MUL partial products.
module fxp_chunk_multiplier #(
    parameter int MUL_CHUNK = 16
) (
    input  logic [MUL_CHUNK-1:0]   a,
    input  logic [MUL_CHUNK-1:0]   b,
    output logic [2*MUL_CHUNK-1:0] product
);
    assign product = (2*MUL_CHUNK)'(a) * (2*MUL_CHUNK)'(b);
endmodule

// File: rtl/fxp_arith_unit.sv
// Signed fixed-point ADD/SUB/MUL/SQRT unit with a start/busy/done handshake.
// state   | meaning
// IDLE    | waiting for start
// ADDSUB  | saturating add/sub, one cycle
// MUL_ACC | one chunk partial product per cycle into the accumulator
// MUL_FIN | round, sign and saturate the product
// SQRT_IT | load radicand, then one root bit per cycle
// DONE    | done pulse; a new start is accepted here
module fxp_arith_unit
    import fxp_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FBITS     = 10,
    parameter int MUL_CHUNK = 16
) (
    input logic             clk,
    input logic             reset,
    fxp_arith_unit_if.slave bus
);
    localparam int N       = WIDTH / MUL_CHUNK;
    localparam int MUL_CYC = N * N;
    localparam int IT      = (WIDTH + FBITS + 1) / 2;
    localparam int RW      = 2 * IT;
    localparam int RMW     = IT + 2;
    localparam int AW      = 2 * WIDTH;
    localparam int CMAX    = (IT > MUL_CYC) ? IT : MUL_CYC;
    localparam int CW      = $clog2(CMAX + 1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    fxp_state_e       state, state_n;
    fxp_op_e          op_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic             ovf_q, inv_q;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    acc;
    logic [RW-1:0]    rad;
    logic [RMW-1:0]   rem;
    logic [IT-1:0]    root;
    logic             busy_w, accept;

    assign busy_w       = state inside {ADDSUB, MUL_ACC, MUL_FIN, SQRT_IT};
    assign accept       = bus.start && !busy_w;
    assign bus.busy     = busy_w;
    assign bus.done     = (state == DONE);
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
    assign bus.invalid  = inv_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    case (bus.operation)
                        FXP_ADD, FXP_SUB: state_n = ADDSUB;
                        FXP_MUL:          state_n = MUL_ACC;
                        default:          state_n = SQRT_IT;
                    endcase
                end else begin
                    state_n = IDLE;
                end
            end
            ADDSUB:  state_n = DONE;
            MUL_ACC: if (cnt == '0) state_n = MUL_FIN;
            MUL_FIN: state_n = DONE;
            SQRT_IT: if (cnt == '0) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // ADD/SUB at WIDTH+1 bits; a sign/carry disagreement means saturation.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] add_res;
    logic             add_ovf;

    always_comb begin
        if (op_q == FXP_SUB) sum = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
        else                 sum = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
        add_ovf = sum[WIDTH] ^ sum[WIDTH-1];
        add_res = add_ovf ? (sum[WIDTH] ? MIN_NEG : MAX_POS) : sum[WIDTH-1:0];
    end

    // Sign-magnitude multiply; the counter value selects the chunk pair.
    logic [WIDTH-1:0]       mag_a, mag_b, mul_res;
    logic [MUL_CHUNK-1:0]   chunk_a, chunk_b;
    logic [2*MUL_CHUNK-1:0] prod;
    logic [AW-1:0]          acc_n, m;
    logic                   mul_neg, mul_ovf;
    int unsigned            idx_a, idx_b;

    fxp_chunk_multiplier #(.MUL_CHUNK(MUL_CHUNK)) u_chunk_mul (
        .a       (chunk_a),
        .b       (chunk_b),
        .product (prod)
    );

    always_comb begin
        mag_a   = a_q[WIDTH-1] ? -a_q : a_q;
        mag_b   = b_q[WIDTH-1] ? -b_q : b_q;
        idx_a   = 32'(cnt) % N;
        idx_b   = 32'(cnt) / N;
        chunk_a = MUL_CHUNK'(mag_a >> (idx_a * MUL_CHUNK));
        chunk_b = MUL_CHUNK'(mag_b >> (idx_b * MUL_CHUNK));
        acc_n   = acc + (AW'(prod) << ((idx_a + idx_b) * MUL_CHUNK));
        m       = (acc + (AW'(1) << (FBITS - 1))) >> FBITS;
        mul_neg = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        mul_ovf = 1'b0;
        mul_res = '0;
        if (m == '0) begin
            mul_res = '0;
        end else if (!mul_neg) begin
            if (m > AW'(MAX_POS)) begin mul_res = MAX_POS; mul_ovf = 1'b1; end
            else                        mul_res = WIDTH'(m);
        end else begin
            if (m > AW'(MIN_NEG)) begin mul_res = MIN_NEG; mul_ovf = 1'b1; end
            else                        mul_res = -(WIDTH'(m));
        end
    end

    // Restoring square root: two radicand bits in, one root bit out per cycle.
    logic [RMW-1:0] rem_t, trial, rem_n;
    logic [IT-1:0]  root_n;
    logic           ge;

    always_comb begin
        rem_t  = RMW'({rem, rad[RW-1:RW-2]});
        trial  = {root, 2'b01};
        ge     = (rem_t >= trial);
        rem_n  = ge ? (rem_t - trial) : rem_t;
        root_n = {root[IT-2:0], ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= FXP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            acc      <= '0;
            rad      <= '0;
            rem      <= '0;
            root     <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= bus.operation;
                a_q  <= bus.operand_1;
                b_q  <= bus.operand_2;
                acc  <= '0;
                cnt  <= (bus.operation == FXP_MUL) ? CW'(MUL_CYC - 1) : CW'(IT);
            end
            case (state)
                ADDSUB: begin
                    result_q <= add_res;
                    ovf_q    <= add_ovf;
                    inv_q    <= 1'b0;
                end
                MUL_ACC: begin
                    acc <= acc_n;
                    cnt <= cnt - CW'(1);
                end
                MUL_FIN: begin
                    result_q <= mul_res;
                    ovf_q    <= mul_ovf;
                    inv_q    <= 1'b0;
                end
                SQRT_IT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(IT)) begin
                        rad  <= RW'({a_q, {FBITS{1'b0}}});
                        rem  <= '0;
                        root <= '0;
                    end else begin
                        rad  <= rad << 2;
                        rem  <= rem_n;
                        root <= root_n;
                    end
                    if (cnt == '0) begin
                        result_q <= a_q[WIDTH-1] ? '0 : WIDTH'(root_n);
                        ovf_q    <= 1'b0;
                        inv_q    <= a_q[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
